alu_mp_sequencer: RTL and testbench
===================================

Name: alu_mp_sequencer

Overview:
Multi-precision controller for the 8-bit RAT ALU. It takes one NBYTES-wide operation and sequences the combinational ALU one byte per clock. It chains carry/borrow and shift bits between bytes and accumulates the zero flag. It owns the ALU's SEL/A/B/CIN inputs while busy and returns wide RESULT, C and Z with a START/DONE handshake.

Parameters:
NBYTES, 4, operand width in bytes (>=2); wide operand width W = 8*NBYTES

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  request; sampled only in IDLE
OP  in  4  operation, same SEL encoding as ALU (0 ADD … 14 MOV, 15 illegal)
OPA  in  W  wide operand A; sampled with START
OPB  in  W  wide operand B; sampled with START
CIN  in  1  carry-in flag; sampled with START
BUSY  out  1  high in RUN and FIN
DONE  out  1  one-cycle completion pulse
ERR  out  1  one-cycle pulse, coincident with DONE, for OP=15
RESULT_MP  out  W  committed wide result
C_OUT  out  1  committed carry/borrow
Z_OUT  out  1  committed zero flag (all W bits zero)
ALU_SEL  out  4  to ALU SEL
ALU_A  out  8  to ALU A
ALU_B  out  8  to ALU B
ALU_CIN  out  1  to ALU CIN
ALU_RESULT  in  8  from ALU RESULT
ALU_C  in  1  from ALU C
ALU_Z  in  1  from ALU Z

Behaviour:
- Reset (async, RST_N=0): state IDLE; RESULT_MP=0, C_OUT=0, Z_OUT=0, BUSY=0, DONE=0, ERR=0; internal regs cleared. Reset mid-operation aborts with no DONE, and committed outputs go to 0.
- The ALU is combinational. ALU_* are driven from the current state, byte index and the latched operands. ALU outputs are captured at the same clock edge.
- IDLE: ALU_SEL=15, ALU_A=ALU_B=0, ALU_CIN=0. When START=1, latch OP/OPA/OPB/CIN, set zacc=1, set idx = 0 (LSB-first ops) or NBYTES-1 (MSB-first ops), and go to RUN. If OP=15, go directly to FIN.
- RUN, one byte per cycle: ALU_A=OPA byte idx, ALU_B=OPB byte idx. Capture ALU_RESULT into work byte idx, chain <= ALU_C, zacc <= zacc & ALU_Z. After NBYTES cycles, go to FIN.
- FIN, one cycle: DONE=1. Commit C_OUT=chain and Z_OUT=zacc. Commit RESULT_MP=work except for CMP(4) and TEST(8), which keep the previous RESULT_MP. Return to IDLE.
- ERR (OP=15): DONE=1 and ERR=1, with no commit of any output.
- Latency: START at edge t gives DONE high during cycle t+NBYTES+1. OP=15 gives DONE during t+1.
- START while BUSY is ignored and is not queued. START high in the FIN cycle is also ignored. The next accept is on the following IDLE cycle.
- Per-op SEL and CIN for the first byte, then later bytes; LSB-first unless noted:
  - ADD: SEL0, then SEL1 with CIN=chain.
  - ADDC: SEL1 with CIN=CIN, then SEL1 with chain.
  - SUB/CMP: SEL2 (CMP uses SEL4), then SEL3 with chain.
  - SUBC: SEL3 with CIN, then SEL3 with chain.
  - AND/OR/XOR/TEST: SEL 5/6/7/8 on every byte, CIN=0; C_OUT=0.
  - LSL: SEL9 with CIN, then SEL9 with chain; C_OUT = OPA[W-1].
  - ROL: SEL9 with CIN=OPA[W-1], then chain.
  - LSR (MSB-first): SEL10 with CIN, then SEL10 with chain; C_OUT = OPA[0].
  - ROR (MSB-first): SEL10 with CIN=OPA[0], then chain.
  - ASR (MSB-first): top byte SEL13, then SEL10 with chain.
  - MOV: SEL14 on every byte; C_OUT=0.
- Byte index wraps never: RUN count is exactly NBYTES. idx increments for LSB-first ops and decrements for MSB-first ops.

Test Plan:
- NBYTES=4, ADD, OPA=0x00FFFFFF, OPB=0x00000001, START at t -> RESULT_MP=0x01000000, C_OUT=0, Z_OUT=0, DONE only in cycle t+5.
- ADD 0xFFFFFFFF+0x00000001 -> RESULT_MP=0, C_OUT=1, Z_OUT=1. Then SUB 0x00000000-0x00000001 -> 0xFFFFFFFF, C_OUT=1, Z_OUT=0.
- With RESULT_MP=0x12345678, CMP OPA=OPB=0xA5A5A5A5 -> Z_OUT=1, C_OUT=0, RESULT_MP stays 0x12345678.
- LSR 0x80000001 with CIN=0 -> 0x40000000, C_OUT=1. ASR 0x80000000 -> 0xC0000000, C_OUT=0. ROL 0x80000001 -> 0x00000003, C_OUT=1.
- START pulsed again at t+2 during ADD -> ignored, exactly one DONE. OP=15 -> DONE and ERR at t+1, outputs unchanged.
- RST_N low at t+2 mid-SUB -> BUSY=0, RESULT_MP=0, C_OUT=0, Z_OUT=0 immediately, no DONE. After release, a new ADD completes normally.

Source files
------------

// File: rtl/alu_mp_sequencer.sv
// Multi-precision sequencer that walks an 8-bit combinational ALU over NBYTES bytes per wide operation.
// Carry/borrow and shift bits chain from byte to byte, the zero flag is ANDed across bytes, and results commit when DONE pulses.
module alu_mp_sequencer #(
  parameter int NBYTES = 4,
  localparam int W = 8 * NBYTES,
  localparam int IW = $clog2(NBYTES)
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic [3:0]   OP,
  input  logic [W-1:0] OPA,
  input  logic [W-1:0] OPB,
  input  logic         CIN,
  output logic         BUSY,
  output logic         DONE,
  output logic         ERR,
  output logic [W-1:0] RESULT_MP,
  output logic         C_OUT,
  output logic         Z_OUT,
  output logic [3:0]   ALU_SEL,
  output logic [7:0]   ALU_A,
  output logic [7:0]   ALU_B,
  output logic         ALU_CIN,
  input  logic [7:0]   ALU_RESULT,
  input  logic         ALU_C,
  input  logic         ALU_Z
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  localparam logic [3:0] OP_ADD = 4'd0, OP_ADDC = 4'd1, OP_SUB = 4'd2, OP_SUBC = 4'd3,
                         OP_CMP = 4'd4, OP_AND = 4'd5, OP_OR = 4'd6, OP_XOR = 4'd7,
                         OP_TEST = 4'd8, OP_LSL = 4'd9, OP_LSR = 4'd10, OP_ROL = 4'd11,
                         OP_ROR = 4'd12, OP_ASR = 4'd13, OP_MOV = 4'd14, OP_ILL = 4'd15;

  state_t         r_state;
  logic [3:0]     r_op;
  logic [W-1:0]   r_opa;
  logic [W-1:0]   r_opb;
  logic [W-1:0]   r_work;
  logic           r_cin;
  logic           r_chain;
  logic           r_zacc;
  logic [IW-1:0]  r_idx;
  logic [IW-1:0]  r_cnt;
  logic           r_busy;
  logic           r_done;
  logic           r_err;
  logic [W-1:0]   r_result;
  logic           r_c;
  logic           r_z;

  logic [7:0]     w_a_bytes [NBYTES];
  logic [7:0]     w_b_bytes [NBYTES];
  logic [W-1:0]   w_work_merged;
  logic           w_first;
  logic           w_last;
  logic           w_c_commit;

  // Shift-right family walks from the top byte down so the shifted-in bit enters at the MSB.
  function automatic logic is_msb_first(input logic [3:0] op);
    return (op == OP_LSR) || (op == OP_ROR) || (op == OP_ASR);
  endfunction

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
    assign w_a_bytes[gi] = r_opa[8*gi +: 8];
    assign w_b_bytes[gi] = r_opb[8*gi +: 8];
    assign w_work_merged[8*gi +: 8] = (r_idx == IW'(gi)) ? ALU_RESULT : r_work[8*gi +: 8];
  end

  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == IW'(NBYTES - 1));

  always_comb begin
    ALU_SEL = OP_ILL;
    ALU_A   = 8'h00;
    ALU_B   = 8'h00;
    ALU_CIN = 1'b0;
    if (r_state == S_RUN) begin
      ALU_A = w_a_bytes[r_idx];
      ALU_B = w_b_bytes[r_idx];
      case (r_op)
        OP_ADD:  begin ALU_SEL = w_first ? OP_ADD : OP_ADDC; ALU_CIN = w_first ? 1'b0 : r_chain; end
        OP_ADDC: begin ALU_SEL = OP_ADDC; ALU_CIN = w_first ? r_cin : r_chain; end
        OP_SUB:  begin ALU_SEL = w_first ? OP_SUB : OP_SUBC; ALU_CIN = w_first ? 1'b0 : r_chain; end
        OP_CMP:  begin ALU_SEL = w_first ? OP_CMP : OP_SUBC; ALU_CIN = w_first ? 1'b0 : r_chain; end
        OP_SUBC: begin ALU_SEL = OP_SUBC; ALU_CIN = w_first ? r_cin : r_chain; end
        OP_AND, OP_OR, OP_XOR, OP_TEST, OP_MOV: ALU_SEL = r_op;
        OP_LSL:  begin ALU_SEL = OP_LSL; ALU_CIN = w_first ? r_cin : r_chain; end
        OP_ROL:  begin ALU_SEL = OP_LSL; ALU_CIN = w_first ? r_opa[W-1] : r_chain; end
        OP_LSR:  begin ALU_SEL = OP_LSR; ALU_CIN = w_first ? r_cin : r_chain; end
        OP_ROR:  begin ALU_SEL = OP_LSR; ALU_CIN = w_first ? r_opa[0] : r_chain; end
        OP_ASR:  begin ALU_SEL = w_first ? OP_ASR : OP_LSR; ALU_CIN = w_first ? 1'b0 : r_chain; end
        default: ALU_SEL = OP_ILL;
      endcase
    end
  end

  always_comb begin
    case (r_op)
      OP_AND, OP_OR, OP_XOR, OP_TEST, OP_MOV: w_c_commit = 1'b0;
      default:                                w_c_commit = ALU_C;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_op     <= 4'd0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_work   <= '0;
      r_cin    <= 1'b0;
      r_chain  <= 1'b0;
      r_zacc   <= 1'b0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
      r_c      <= 1'b0;
      r_z      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_op    <= OP;
            r_opa   <= OPA;
            r_opb   <= OPB;
            r_cin   <= CIN;
            r_zacc  <= 1'b1;
            r_chain <= 1'b0;
            r_cnt   <= '0;
            r_idx   <= is_msb_first(OP) ? IW'(NBYTES - 1) : '0;
            r_busy  <= 1'b1;
            if (OP == OP_ILL) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_work  <= w_work_merged;
          r_chain <= ALU_C;
          r_zacc  <= r_zacc & ALU_Z;
          r_cnt   <= r_cnt + 1'b1;
          r_idx   <= is_msb_first(r_op) ? r_idx - 1'b1 : r_idx + 1'b1;
          // Commit on the last byte so the results are already visible while DONE is high.
          if (w_last) begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
            r_c     <= w_c_commit;
            r_z     <= r_zacc & ALU_Z;
            if (r_op != OP_CMP && r_op != OP_TEST)
              r_result <= w_work_merged;
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign ERR       = r_err;
  assign RESULT_MP = r_result;
  assign C_OUT     = r_c;
  assign Z_OUT     = r_z;

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// Randomized and directed bench for alu_mp_sequencer with a byte ALU model and a wide-arithmetic reference.
module tb_alu_mp_sequencer;
  localparam int NBYTES = 4;
  localparam int W = 8 * NBYTES;

  logic         CLK, RST_N, START, CIN;
  logic [3:0]   OP;
  logic [W-1:0] OPA, OPB;
  logic         BUSY, DONE, ERR, C_OUT, Z_OUT;
  logic [W-1:0] RESULT_MP;
  logic [3:0]   ALU_SEL;
  logic [7:0]   ALU_A, ALU_B, ALU_RESULT;
  logic         ALU_CIN, ALU_C, ALU_Z;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] m_res;
  logic         m_c, m_z;

  alu_mp_sequencer #(.NBYTES(NBYTES)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .OP(OP), .OPA(OPA), .OPB(OPB), .CIN(CIN),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RESULT_MP(RESULT_MP), .C_OUT(C_OUT), .Z_OUT(Z_OUT),
    .ALU_SEL(ALU_SEL), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_CIN(ALU_CIN),
    .ALU_RESULT(ALU_RESULT), .ALU_C(ALU_C), .ALU_Z(ALU_Z)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // 8-bit RAT ALU behaviour
  always_comb begin
    logic [8:0] t;
    t = 9'd0;
    case (ALU_SEL)
      4'd0:       t = {1'b0, ALU_A} + {1'b0, ALU_B};
      4'd1:       t = {1'b0, ALU_A} + {1'b0, ALU_B} + {8'd0, ALU_CIN};
      4'd2, 4'd4: t = {1'b0, ALU_A} - {1'b0, ALU_B};
      4'd3:       t = {1'b0, ALU_A} - {1'b0, ALU_B} - {8'd0, ALU_CIN};
      4'd5, 4'd8: t = {1'b0, ALU_A & ALU_B};
      4'd6:       t = {1'b0, ALU_A | ALU_B};
      4'd7:       t = {1'b0, ALU_A ^ ALU_B};
      4'd9:       t = {ALU_A[7], ALU_A[6:0], ALU_CIN};
      4'd10:      t = {ALU_A[0], ALU_CIN, ALU_A[7:1]};
      4'd11:      t = {ALU_A[7], ALU_A[6:0], ALU_A[7]};
      4'd12:      t = {ALU_A[0], ALU_A[0], ALU_A[7:1]};
      4'd13:      t = {ALU_A[0], ALU_A[7], ALU_A[7:1]};
      4'd14:      t = {1'b0, ALU_B};
      default:    t = 9'd0;
    endcase
    ALU_RESULT = t[7:0];
    ALU_C      = t[8];
    ALU_Z      = (t[7:0] == 8'd0);
  end

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Whole-word reference of each operation
  task automatic model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0]   t;
    logic [W-1:0] r;
    logic         c;
    r = '0;
    c = 1'b0;
    case (op)
      4'd0:  begin t = {1'b0, a} + {1'b0, b}; r = t[W-1:0]; c = t[W]; end
      4'd1:  begin t = {1'b0, a} + {1'b0, b} + (W+1)'(ci); r = t[W-1:0]; c = t[W]; end
      4'd2, 4'd4: begin r = a - b; c = (a < b); end
      4'd3:  begin r = a - b - W'(ci); c = ({1'b0, a} < ({1'b0, b} + (W+1)'(ci))); end
      4'd5, 4'd8: r = a & b;
      4'd6:  r = a | b;
      4'd7:  r = a ^ b;
      4'd9:  begin r = {a[W-2:0], ci};     c = a[W-1]; end
      4'd10: begin r = {ci, a[W-1:1]};     c = a[0];   end
      4'd11: begin r = {a[W-2:0], a[W-1]}; c = a[W-1]; end
      4'd12: begin r = {a[0], a[W-1:1]};   c = a[0];   end
      4'd13: begin r = {a[W-1], a[W-1:1]}; c = a[0];   end
      4'd14: r = b;
      default: ;
    endcase
    if (op != 4'd15) begin
      m_c = c;
      m_z = (r == '0);
      if (op != 4'd4 && op != 4'd8) m_res = r;
    end
  endtask

  // Issues one request; optional stray START pulse or reset at cycle 2 of the operation.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input bit stray_start, input bit mid_reset);
    int done_k = 0;
    int done_cnt = 0;
    int exp_k;
    logic err_seen = 1'b0;
    logic busy_at_done = 1'b0;
    exp_k = (op == 4'd15) ? 1 : NBYTES + 1;
    @(negedge CLK);
    OP = op; OPA = a; OPB = b; CIN = ci; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    OPA = $urandom; OPB = $urandom;
    for (int k = 1; k <= NBYTES + 6; k++) begin
      if (DONE) begin
        done_cnt++;
        done_k = k;
        err_seen = ERR;
        busy_at_done = BUSY;
      end
      if (stray_start && k == 1) begin OP = 4'd14; OPB = '1; START = 1'b1; end
      if (stray_start && k == 2) START = 1'b0;
      if (mid_reset && k == 2) begin
        RST_N = 1'b0;
        #1;
        check_val("rst_busy", W'(BUSY), '0);
        check_val("rst_result", RESULT_MP, '0);
        check_val("rst_c", W'(C_OUT), '0);
        check_val("rst_z", W'(Z_OUT), '0);
        m_res = '0; m_c = 1'b0; m_z = 1'b0;
      end
      if (mid_reset && k == 3) RST_N = 1'b1;
      @(negedge CLK);
    end
    if (!mid_reset) model_op(op, a, b, ci);
    check_val("done_count", W'(done_cnt), mid_reset ? '0 : W'(1));
    if (!mid_reset) begin
      check_val("done_cycle", W'(done_k), W'(exp_k));
      check_val("err", W'(err_seen), W'(op == 4'd15));
      check_val("busy_at_done", W'(busy_at_done), W'(1));
    end
    check_val("result", RESULT_MP, m_res);
    check_val("c_out", W'(C_OUT), W'(m_c));
    check_val("z_out", W'(Z_OUT), W'(m_z));
    $display("op=%0d a=%h b=%h cin=%0d -> result=%h c=%0d z=%0d done_cycle=%0d", op, a, b, ci,
             RESULT_MP, C_OUT, Z_OUT, done_k);
  endtask

  initial begin
    RST_N = 1'b0; START = 1'b0; OP = 4'd0; OPA = '0; OPB = '0; CIN = 1'b0;
    m_res = '0; m_c = 1'b0; m_z = 1'b0;
    repeat (2) @(negedge CLK);
    check_val("reset_busy", W'(BUSY), '0);
    check_val("reset_done", W'(DONE), '0);
    check_val("reset_result", RESULT_MP, '0);
    check_val("reset_alu_sel", W'(ALU_SEL), W'(15));
    RST_N = 1'b1;

    run_op(4'd0,  32'h00FFFFFF, 32'h00000001, 1'b0, 0, 0);
    run_op(4'd0,  32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 0);
    run_op(4'd2,  32'h00000000, 32'h00000001, 1'b0, 0, 0);
    run_op(4'd14, 32'h0, 32'h12345678, 1'b0, 0, 0);
    run_op(4'd4,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 0, 0);
    run_op(4'd10, 32'h80000001, 32'h0, 1'b0, 0, 0);
    run_op(4'd13, 32'h80000000, 32'h0, 1'b0, 0, 0);
    run_op(4'd11, 32'h80000001, 32'h0, 1'b0, 0, 0);
    run_op(4'd0,  32'h11111111, 32'h22222222, 1'b0, 1, 0);
    run_op(4'd15, 32'hDEADBEEF, 32'h1, 1'b1, 0, 0);
    run_op(4'd2,  32'h87654321, 32'h12345678, 1'b0, 0, 1);
    run_op(4'd0,  32'h00000005, 32'h00000007, 1'b0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      logic [3:0]   op;
      logic [W-1:0] a, b;
      op = 4'($urandom_range(15));
      a = $urandom;
      b = ($urandom_range(3) == 0) ? a : W'($urandom);
      run_op(op, a, b, 1'($urandom_range(1)), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
